// File: rtl/tcdm_mp_sim_memory.sv
// Multi-port byte-addressed simulation memory with a TCDM request/grant/response
// protocol: combinational grant, one-cycle registered response, wrapping address window.
module tcdm_mp_sim_memory #(
    parameter int unsigned MP          = 1,
    parameter int unsigned MEMORY_SIZE = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [MP-1:0]        tcdm_req_i,
    input  logic [MP-1:0][31:0]  tcdm_add_i,
    input  logic [MP-1:0]        tcdm_wen_i,
    input  logic [MP-1:0][3:0]   tcdm_be_i,
    input  logic [MP-1:0][31:0]  tcdm_data_i,
    output logic [MP-1:0]        tcdm_gnt_o,
    output logic [MP-1:0][31:0]  tcdm_r_data_o,
    output logic [MP-1:0]        tcdm_r_valid_o
);

    localparam int unsigned AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    typedef logic [AW-1:0] idx_t;

    // Zero at time 0 so unwritten locations never read back as X; backdoor loads follow.
    logic [7:0] memory [0:MEMORY_SIZE-1] = '{default: 8'h00};

    function automatic idx_t byte_idx(input logic [31:0] add, input int unsigned k);
        logic [63:0] off;
        logic [63:0] pos;
        off = 64'((add - BASE_ADDR) & ~32'h3) % 64'(MEMORY_SIZE);
        pos = (off + 64'(k)) % 64'(MEMORY_SIZE);
        return pos[AW-1:0];
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] add);
        logic [31:0] w;
        w = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w[8*k +: 8] = memory[byte_idx(add, k)];
        end
        return w;
    endfunction

    always_comb begin
        tcdm_gnt_o = tcdm_req_i & {MP{enable_i}};
    end

    // Memory shares the async-reset process but is left out of the reset branch:
    // contents survive reset and no write lands while rst_ni is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcdm_r_valid_o <= '0;
            tcdm_r_data_o  <= '0;
        end else begin
            for (int unsigned i = 0; i < MP; i++) begin
                tcdm_r_valid_o[i] <= tcdm_gnt_o[i];
                if (tcdm_gnt_o[i] && tcdm_wen_i[i]) begin
                    tcdm_r_data_o[i] <= read_word(tcdm_add_i[i]);
                end
                // Later ports overwrite earlier ones on the same byte.
                if (tcdm_gnt_o[i] && !tcdm_wen_i[i]) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (tcdm_be_i[i][k]) begin
                            memory[byte_idx(tcdm_add_i[i], k)] <= tcdm_data_i[i][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tcdm_mp_sim_memory.sv
// Directed self-checking bench for tcdm_mp_sim_memory: a 3-port windowed
// instance and a 1-port wrapping instance sharing clock and reset.
module tb_tcdm_mp_sim_memory;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b1;

    logic [2:0]        req_a  = '0;
    logic [2:0][31:0]  add_a  = '0;
    logic [2:0]        wen_a  = '0;
    logic [2:0][3:0]   be_a   = '0;
    logic [2:0][31:0]  data_a = '0;
    logic [2:0]        gnt_a;
    logic [2:0][31:0]  rdata_a;
    logic [2:0]        rvalid_a;

    logic              req_b  = 1'b0;
    logic [31:0]       add_b  = '0;
    logic              wen_b  = 1'b0;
    logic [3:0]        be_b   = '0;
    logic [31:0]       data_b = '0;
    logic              gnt_b;
    logic [31:0]       rdata_b;
    logic              rvalid_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    tcdm_mp_sim_memory #(
        .MP          (3),
        .MEMORY_SIZE (1118496),
        .BASE_ADDR   (32'h0010_0000)
    ) dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .tcdm_req_i     (req_a),
        .tcdm_add_i     (add_a),
        .tcdm_wen_i     (wen_a),
        .tcdm_be_i      (be_a),
        .tcdm_data_i    (data_a),
        .tcdm_gnt_o     (gnt_a),
        .tcdm_r_data_o  (rdata_a),
        .tcdm_r_valid_o (rvalid_a)
    );

    tcdm_mp_sim_memory #(
        .MP          (1),
        .MEMORY_SIZE (32'h0003_0000),
        .BASE_ADDR   (32'h0)
    ) dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .tcdm_req_i     (req_b),
        .tcdm_add_i     (add_b),
        .tcdm_wen_i     (wen_b),
        .tcdm_be_i      (be_b),
        .tcdm_data_i    (data_b),
        .tcdm_gnt_o     (gnt_b),
        .tcdm_r_data_o  (rdata_b),
        .tcdm_r_valid_o (rvalid_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_a(input int unsigned p, input logic wen, input logic [31:0] add,
                         input logic [31:0] data, input logic [3:0] be);
        req_a[p]  = 1'b1;
        wen_a[p]  = wen;
        add_a[p]  = add;
        data_a[p] = data;
        be_a[p]   = be;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        dut_a.memory[32'h80] = 8'h13;
        dut_a.memory[32'h81] = 8'h05;
        dut_a.memory[32'h82] = 8'h00;
        dut_a.memory[32'h83] = 8'h00;

        cycle();
        check("rst_valid", 32'(rvalid_a), 32'h0);
        check("rst_data", rdata_a[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // backdoor-loaded word
        @(negedge clk);
        req_a = '0;
        set_a(0, 1'b1, 32'h0010_0080, 32'h0, 4'h0);
        #1 check("rd_gnt", 32'(gnt_a), 32'h1);
        cycle();
        check("rd_valid", 32'(rvalid_a), 32'h1);
        check("rd_data", rdata_a[0], 32'h0000_0513);

        // byte-enable writes
        @(negedge clk);
        set_a(0, 1'b0, 32'h0010_0010, 32'hAABB_CCDD, 4'b1111);
        cycle();
        check("wr1_valid", 32'(rvalid_a), 32'h1);
        check("wr1_hold", rdata_a[0], 32'h0000_0513);
        @(negedge clk);
        set_a(0, 1'b0, 32'h0010_0010, 32'h1122_3344, 4'b0101);
        cycle();
        check("wr2_valid", 32'(rvalid_a), 32'h1);
        @(negedge clk);
        set_a(0, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        cycle();
        check("be_valid", 32'(rvalid_a), 32'h1);
        check("be_data", rdata_a[0], 32'hAA22_CC44);
        @(negedge clk);
        req_a = '0;
        cycle();
        check("idle_valid", 32'(rvalid_a), 32'h0);

        // wrap-around: 0x140000 mod 0x30000 = 0x20000
        @(negedge clk);
        req_b = 1'b1; wen_b = 1'b0; add_b = 32'h0014_0000; data_b = 32'hDEAD_BEEF; be_b = 4'hF;
        #1 check("wrap_gnt", 32'(gnt_b), 32'h1);
        cycle();
        check("wrap_wvalid", 32'(rvalid_b), 32'h1);
        @(negedge clk);
        wen_b = 1'b1; add_b = 32'h0002_0000;
        cycle();
        check("wrap_data", rdata_b, 32'hDEAD_BEEF);
        @(negedge clk);
        req_b = 1'b0;

        // read-before-write across ports
        req_a = '0;
        set_a(0, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        set_a(1, 1'b0, 32'h0010_0010, 32'h1234_5678, 4'hF);
        #1 check("rbw_gnt", 32'(gnt_a), 32'h3);
        cycle();
        check("rbw_valid", 32'(rvalid_a), 32'h3);
        check("rbw_data", rdata_a[0], 32'hAA22_CC44);

        // same-word collision, highest port wins
        @(negedge clk);
        req_a = '0;
        set_a(0, 1'b0, 32'h0010_0020, 32'h0BAD_F00D, 4'hF);
        set_a(2, 1'b0, 32'h0010_0020, 32'hCAFE_BABE, 4'hF);
        #1 check("coll_gnt", 32'(gnt_a), 32'h5);
        cycle();
        check("coll_valid", 32'(rvalid_a), 32'h5);
        @(negedge clk);
        req_a = '0;
        set_a(1, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        set_a(2, 1'b1, 32'h0010_0020, 32'h0, 4'h0);
        cycle();
        check("p1_data", rdata_a[1], 32'h1234_5678);
        check("coll_data", rdata_a[2], 32'hCAFE_BABE);

        // global enable low
        @(negedge clk);
        req_a  = '0;
        enable = 1'b0;
        set_a(0, 1'b0, 32'h0010_0010, 32'h5555_5555, 4'hF);
        set_a(2, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        #1 check("dis_gnt", 32'(gnt_a), 32'h0);
        cycle();
        check("dis_valid", 32'(rvalid_a), 32'h0);
        check("dis_hold", rdata_a[2], 32'hCAFE_BABE);
        @(negedge clk);
        enable = 1'b1;
        req_a  = '0;
        set_a(0, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        cycle();
        check("dis_mem", rdata_a[0], 32'h1234_5678);

        // asynchronous reset
        @(negedge clk);
        req_a = '0;
        set_a(0, 1'b1, 32'h0010_0020, 32'h0, 4'h0);
        cycle();
        check("pre_rst_valid", 32'(rvalid_a), 32'h1);
        check("pre_rst_data", rdata_a[0], 32'hCAFE_BABE);
        @(negedge clk);
        set_a(0, 1'b1, 32'h0010_0010, 32'h0, 4'h0);
        set_a(1, 1'b0, 32'h0010_0020, 32'h0, 4'hF);
        #2 rst_n = 1'b0;
        #1 check("rst_async_valid", 32'(rvalid_a), 32'h0);
        check("rst_async_data", rdata_a[0], 32'h0);
        cycle();
        check("rst_no_resp", 32'(rvalid_a), 32'h0);
        @(negedge clk);
        req_a = '0;
        rst_n = 1'b1;
        @(negedge clk);
        set_a(0, 1'b1, 32'h0010_0020, 32'h0, 4'h0);
        cycle();
        check("post_rst_valid", 32'(rvalid_a), 32'h1);
        check("post_rst_data", rdata_a[0], 32'hCAFE_BABE);
        @(negedge clk);
        req_a = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
